// File: rtl/menu_overlay.sv
// ============================================================================
// Module   : menu_overlay
// Summary  : N-item on-screen menu with cursor navigation, numeric selection,
//            and a video pass-through that paints the box and cursor row.
// Revision : 1.0
// ============================================================================
`default_nettype none

module menu_overlay #(
  parameter int          ITEMS     = 3,
  parameter logic [7:0]  KEY_OPEN  = 8'h1B,
  parameter logic [7:0]  KEY_UP    = 8'h77,
  parameter logic [7:0]  KEY_DOWN  = 8'h73,
  parameter logic [7:0]  KEY_ENTER = 8'h0D,
  parameter int          HOLDOFF   = 4,
  parameter int          PIPE_DEL  = 2,
  parameter int          BOX_X     = 448,
  parameter int          BOX_Y     = 256,
  parameter int          BOX_W     = 128,
  parameter int          ROW_H     = 16,
  parameter logic [11:0] BG_COLOR  = 12'h777,
  parameter logic [11:0] HL_COLOR  = 12'hFF0,
  localparam int         CW        = (ITEMS > 1) ? $clog2(ITEMS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    key,
  input  logic [15:0]   hcount_in,
  input  logic [15:0]   vcount_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [11:0]   rgb_in,
  output logic [15:0]   hcount_out,
  output logic [15:0]   vcount_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [11:0]   rgb_out,
  output logic          menu_active,
  output logic [CW-1:0] cursor,
  output logic          select_valid,
  output logic [CW-1:0] select_idx
);

  localparam int HW        = $clog2(HOLDOFF + 1);
  localparam int ROW_SHIFT = $clog2(ROW_H);
  localparam int PW        = 48;

  localparam logic [HW-1:0] C_HOLD      = HW'(HOLDOFF);
  localparam logic [CW-1:0] C_LAST      = CW'(ITEMS - 1);
  localparam logic [7:0]    C_DIGIT_MAX = 8'(48 + ITEMS);
  localparam logic [15:0]   C_X_LO      = 16'(BOX_X);
  localparam logic [15:0]   C_X_HI      = 16'(BOX_X + BOX_W);
  localparam logic [15:0]   C_Y_LO      = 16'(BOX_Y);
  localparam logic [15:0]   C_Y_HI      = 16'(BOX_Y + ITEMS * ROW_H);

  // Row index is a plain shift, so the row height has to be a power of two.
  if (ROW_H <= 0 || (ROW_H & (ROW_H - 1)) != 0) begin : g_row_h_check
    $error("menu_overlay: ROW_H must be a power of two");
  end
  if (ITEMS < 1 || ITEMS > 9) begin : g_items_check
    $error("menu_overlay: ITEMS must be in 1..9");
  end

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_hold;
  logic          r_active;
  logic [CW-1:0] r_cursor;
  logic          r_sel_valid;
  logic [CW-1:0] r_sel_idx;

  logic          w_accept;
  logic          w_is_digit;
  logic [CW-1:0] w_digit_idx;
  logic [CW-1:0] w_cur_up;
  logic [CW-1:0] w_cur_dn;

  assign w_accept    = (key != 8'h00) && (r_hold == '0);
  assign w_is_digit  = (key >= 8'h31) && (key <= C_DIGIT_MAX);
  assign w_digit_idx = CW'(key - 8'h31);
  assign w_cur_up    = (r_cursor == '0) ? C_LAST : r_cursor - CW'(1);
  assign w_cur_dn    = (r_cursor == C_LAST) ? '0 : r_cursor + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLOSED;
      r_hold      <= '0;
      r_active    <= 1'b0;
      r_cursor    <= '0;
      r_sel_valid <= 1'b0;
      r_sel_idx   <= '0;
    end else begin
      // Keys seen during the confirm cycle are dropped without arming holdoff.
      if (w_accept && r_state != ST_CONFIRM)
        r_hold <= C_HOLD;
      else if (r_hold != '0)
        r_hold <= r_hold - HW'(1);

      r_sel_valid <= 1'b0;

      case (r_state)
        ST_CLOSED: begin
          if (w_accept && key == KEY_OPEN) begin
            r_state  <= ST_OPEN;
            r_active <= 1'b1;
            r_cursor <= '0;
          end
        end
        ST_OPEN: begin
          if (w_accept) begin
            if (key == KEY_OPEN) begin
              r_state  <= ST_CLOSED;
              r_active <= 1'b0;
            end else if (key == KEY_UP) begin
              r_cursor <= w_cur_up;
            end else if (key == KEY_DOWN) begin
              r_cursor <= w_cur_dn;
            end else if (key == KEY_ENTER) begin
              r_state     <= ST_CONFIRM;
              r_sel_valid <= 1'b1;
              r_sel_idx   <= r_cursor;
            end else if (w_is_digit) begin
              r_state     <= ST_CONFIRM;
              r_sel_valid <= 1'b1;
              r_sel_idx   <= w_digit_idx;
              r_cursor    <= w_digit_idx;
            end
          end
        end
        ST_CONFIRM: begin
          r_state  <= ST_CLOSED;
          r_active <= 1'b0;
        end
        default: begin
          r_state  <= ST_CLOSED;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign menu_active  = r_active;
  assign cursor       = r_cursor;
  assign select_valid = r_sel_valid;
  assign select_idx   = r_sel_idx;

  // Box/row decisions are made on the undelayed counters and travel with the pixel.
  logic          w_in_box;
  logic [15:0]   w_row;
  logic          w_hl;
  logic          w_bg;
  logic [PW-1:0] w_entry;
  logic [PW-1:0] w_tail;
  logic [PW-1:0] r_pipe [PIPE_DEL];

  assign w_in_box = (hcount_in >= C_X_LO) && (hcount_in < C_X_HI) &&
                    (vcount_in >= C_Y_LO) && (vcount_in < C_Y_HI);
  assign w_row    = (vcount_in - C_Y_LO) >> ROW_SHIFT;
  assign w_bg     = r_active && w_in_box;
  assign w_hl     = w_bg && (w_row == 16'(r_cursor));
  assign w_entry  = {w_hl, w_bg, hsync_in, vsync_in, hcount_in, vcount_in, rgb_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEL; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_entry;
      for (int i = 1; i < PIPE_DEL; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail     = r_pipe[PIPE_DEL-1];
  assign hsync_out  = w_tail[45];
  assign vsync_out  = w_tail[44];
  assign hcount_out = w_tail[43:28];
  assign vcount_out = w_tail[27:12];
  assign rgb_out    = w_tail[47] ? HL_COLOR :
                      w_tail[46] ? BG_COLOR : w_tail[11:0];

endmodule

`default_nettype wire
